// File: rtl/replica_pkg.sv
// Shared types for the 2-opt / or-opt replica datapath: opt requests,
// distance-unit commands and beat-count constants.
package replica_pkg;

    localparam int city_num      = 30;
    localparam int opt_beats_two = 5;
    localparam int opt_beats_or  = 7;

    typedef enum logic [1:0] {
        TWO = 2'd0,
        OR0 = 2'd1,
        OR1 = 2'd2,
        THR = 2'd3
    } opt_command;

    typedef struct packed {
        opt_command command;
        logic [6:0] k;
        logic [6:0] l;
    } opt_t;

    typedef enum logic [2:0] {
        KN = 3'd0,
        KM = 3'd1,
        KP = 3'd2,
        LN = 3'd3,
        LM = 3'd4,
        LP = 3'd5
    } distance_select_t;

    typedef enum logic [1:0] {
        DNOP = 2'd0,
        ZERO = 2'd1,
        MNS  = 2'd2,
        PLS  = 2'd3
    } distance_op_t;

    typedef struct packed {
        distance_select_t sel;
        distance_op_t     op;
    } distance_command_t;

endpackage

// File: rtl/opt_dist_seq.sv
// Expands one accepted opt request into the sequence of distance-unit beats
// (edge terms to subtract/add) that evaluate the tour-length delta.
module opt_dist_seq #(
    parameter int city_num = replica_pkg::city_num
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  replica_pkg::opt_t             in_opt,
    output logic                          out_valid,
    input  logic                          out_ready,
    output replica_pkg::distance_command_t out_cmd,
    output logic [6:0]                    out_pos_a,
    output logic [6:0]                    out_pos_b,
    output logic                          out_last,
    output logic                          out_err
);

    localparam logic [6:0] LAST_POS     = 7'(city_num - 1);
    localparam logic [2:0] BEATS_TWO_M1 = 3'(replica_pkg::opt_beats_two - 1);
    localparam logic [2:0] BEATS_OR_M1  = 3'(replica_pkg::opt_beats_or - 1);

    typedef enum logic {S_IDLE, S_RUN} state_t;

    state_t                  state_q, state_d;
    logic [2:0]              cnt_q, cnt_d;
    replica_pkg::opt_command cmd_q, cmd_d;
    logic [6:0]              k_q, k_d, l_q, l_d;
    logic [6:0]              km_q, km_d, kn_q, kn_d, ln_q, ln_d;
    logic                    err_q, err_d;

    logic                    run, fire, accept, is_last;
    logic [2:0]              last_idx;
    replica_pkg::distance_select_t beat_sel;
    replica_pkg::distance_op_t     beat_op;
    logic [6:0]              beat_a, beat_b;

    function automatic logic [6:0] pos_inc(input logic [6:0] p);
        return (p == LAST_POS) ? 7'd0 : p + 7'd1;
    endfunction

    function automatic logic [6:0] pos_dec(input logic [6:0] p);
        return (p == 7'd0) ? LAST_POS : p - 7'd1;
    endfunction

    // Handshake and next-state logic; a new opt may be taken on the same
    // edge that consumes the final beat of the current one.
    always_comb begin
        run = (state_q == S_RUN);
        if (err_q)
            last_idx = 3'd0;
        else if (cmd_q == replica_pkg::TWO)
            last_idx = BEATS_TWO_M1;
        else
            last_idx = BEATS_OR_M1;
        is_last  = (cnt_q == last_idx);
        fire     = run && out_ready;
        in_ready = !reset && (!run || (fire && is_last));
        accept   = in_valid && in_ready;

        state_d = state_q;
        cnt_d   = cnt_q;
        cmd_d   = cmd_q;
        k_d     = k_q;
        l_d     = l_q;
        km_d    = km_q;
        kn_d    = kn_q;
        ln_d    = ln_q;
        err_d   = err_q;

        if (accept) begin
            state_d = S_RUN;
            cnt_d   = 3'd0;
            cmd_d   = in_opt.command;
            k_d     = in_opt.k;
            l_d     = in_opt.l;
            km_d    = pos_dec(in_opt.k);
            kn_d    = pos_inc(in_opt.k);
            ln_d    = pos_inc(in_opt.l);
            err_d   = (in_opt.command == replica_pkg::THR) ||
                      (in_opt.k > LAST_POS) || (in_opt.l > LAST_POS);
        end else if (fire) begin
            if (is_last) begin
                state_d = S_IDLE;
                cnt_d   = 3'd0;
            end else begin
                cnt_d = cnt_q + 3'd1;
            end
        end
    end

    // Beat table: one edge term per {command, beat index}.
    always_comb begin
        beat_sel = replica_pkg::KN;
        beat_op  = replica_pkg::DNOP;
        beat_a   = 7'd0;
        beat_b   = 7'd0;
        if (err_q) begin
            beat_op = replica_pkg::ZERO;
        end else begin
            case ({cmd_q, cnt_q})
                {replica_pkg::TWO, 3'd0},
                {replica_pkg::OR0, 3'd0},
                {replica_pkg::OR1, 3'd0}: begin
                    beat_op = replica_pkg::ZERO;
                end
                {replica_pkg::TWO, 3'd1}: begin
                    beat_sel = replica_pkg::KN; beat_op = replica_pkg::MNS;
                    beat_a   = k_q;             beat_b  = kn_q;
                end
                {replica_pkg::TWO, 3'd2}: begin
                    beat_sel = replica_pkg::LN; beat_op = replica_pkg::MNS;
                    beat_a   = l_q;             beat_b  = ln_q;
                end
                {replica_pkg::TWO, 3'd3}: begin
                    beat_sel = replica_pkg::LM; beat_op = replica_pkg::PLS;
                    beat_a   = k_q;             beat_b  = l_q;
                end
                {replica_pkg::TWO, 3'd4}: begin
                    beat_sel = replica_pkg::LP; beat_op = replica_pkg::PLS;
                    beat_a   = kn_q;            beat_b  = ln_q;
                end
                {replica_pkg::OR0, 3'd1},
                {replica_pkg::OR1, 3'd1}: begin
                    beat_sel = replica_pkg::KM; beat_op = replica_pkg::MNS;
                    beat_a   = km_q;            beat_b  = k_q;
                end
                {replica_pkg::OR0, 3'd2},
                {replica_pkg::OR1, 3'd2}: begin
                    beat_sel = replica_pkg::KN; beat_op = replica_pkg::MNS;
                    beat_a   = k_q;             beat_b  = kn_q;
                end
                {replica_pkg::OR0, 3'd3},
                {replica_pkg::OR1, 3'd3}: begin
                    beat_sel = replica_pkg::LN; beat_op = replica_pkg::MNS;
                    beat_a   = l_q;             beat_b  = ln_q;
                end
                {replica_pkg::OR0, 3'd4},
                {replica_pkg::OR1, 3'd4}: begin
                    beat_sel = replica_pkg::KP; beat_op = replica_pkg::PLS;
                    beat_a   = km_q;            beat_b  = kn_q;
                end
                {replica_pkg::OR0, 3'd5},
                {replica_pkg::OR1, 3'd5}: begin
                    beat_sel = replica_pkg::LM; beat_op = replica_pkg::PLS;
                    beat_a   = l_q;             beat_b  = k_q;
                end
                {replica_pkg::OR0, 3'd6},
                {replica_pkg::OR1, 3'd6}: begin
                    beat_sel = replica_pkg::LP; beat_op = replica_pkg::PLS;
                    beat_a   = k_q;             beat_b  = ln_q;
                end
                default: begin
                    beat_sel = replica_pkg::KN;
                    beat_op  = replica_pkg::DNOP;
                end
            endcase
        end
    end

    // Outputs are forced to their idle values outside RUN and during reset.
    always_comb begin
        out_valid   = run && !reset;
        out_cmd.sel = replica_pkg::KN;
        out_cmd.op  = replica_pkg::DNOP;
        out_pos_a   = 7'd0;
        out_pos_b   = 7'd0;
        out_last    = 1'b0;
        out_err     = 1'b0;
        if (out_valid) begin
            out_cmd.sel = beat_sel;
            out_cmd.op  = beat_op;
            out_pos_a   = beat_a;
            out_pos_b   = beat_b;
            out_last    = is_last;
            out_err     = is_last && err_q;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= 3'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Opt operands only matter in RUN, which always begins with a capture.
    always_ff @(posedge clk) begin
        cmd_q <= cmd_d;
        k_q   <= k_d;
        l_q   <= l_d;
        km_q  <= km_d;
        kn_q  <= kn_d;
        ln_q  <= ln_d;
        err_q <= err_d;
    end

endmodule

// File: tb/tb_opt_dist_seq.sv
// Scoreboard bench for opt_dist_seq: expected beats are queued from a
// reference model when an opt is accepted and popped as beats are consumed.
module tb_opt_dist_seq;
    import replica_pkg::*;

    logic              clk = 1'b0;
    logic              reset;
    logic              in_valid;
    logic              in_ready;
    opt_t              in_opt;
    logic              out_valid;
    logic              out_ready;
    distance_command_t out_cmd;
    logic [6:0]        out_pos_a;
    logic [6:0]        out_pos_b;
    logic              out_last;
    logic              out_err;

    typedef struct packed {
        distance_select_t sel;
        distance_op_t     op;
        logic [6:0]       a;
        logic [6:0]       b;
        logic             last;
        logic             err;
    } beat_t;

    beat_t sb[$];
    int    vectors     = 0;
    int    miscompares = 0;

    always #5 clk = ~clk;

    opt_dist_seq #(.city_num(city_num)) dut (
        .clk      (clk),
        .reset    (reset),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_opt   (in_opt),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_cmd  (out_cmd),
        .out_pos_a(out_pos_a),
        .out_pos_b(out_pos_b),
        .out_last (out_last),
        .out_err  (out_err)
    );

    function automatic opt_t mk(opt_command c, int k, int l);
        opt_t o;
        o.command = c;
        o.k       = 7'(k);
        o.l       = 7'(l);
        return o;
    endfunction

    function automatic int nbeats(opt_t o);
        if (o.command == THR || int'(o.k) >= city_num || int'(o.l) >= city_num) return 1;
        if (o.command == TWO) return opt_beats_two;
        return opt_beats_or;
    endfunction

    function automatic beat_t model(opt_t o, int i);
        beat_t e;
        int k, l, km, kp, lp, n;
        k  = int'(o.k);
        l  = int'(o.l);
        km = (k + city_num - 1) % city_num;
        kp = (k + 1) % city_num;
        lp = (l + 1) % city_num;
        n  = nbeats(o);
        e.sel  = KN;
        e.op   = ZERO;
        e.a    = 7'd0;
        e.b    = 7'd0;
        e.last = (i == n - 1);
        e.err  = (n == 1);
        if (n == 1 || i == 0) return e;
        if (o.command == TWO) begin
            case (i)
                1: begin e.sel = KN; e.op = MNS; e.a = 7'(k);  e.b = 7'(kp); end
                2: begin e.sel = LN; e.op = MNS; e.a = 7'(l);  e.b = 7'(lp); end
                3: begin e.sel = LM; e.op = PLS; e.a = 7'(k);  e.b = 7'(l);  end
                default: begin e.sel = LP; e.op = PLS; e.a = 7'(kp); e.b = 7'(lp); end
            endcase
        end else begin
            case (i)
                1: begin e.sel = KM; e.op = MNS; e.a = 7'(km); e.b = 7'(k);  end
                2: begin e.sel = KN; e.op = MNS; e.a = 7'(k);  e.b = 7'(kp); end
                3: begin e.sel = LN; e.op = MNS; e.a = 7'(l);  e.b = 7'(lp); end
                4: begin e.sel = KP; e.op = PLS; e.a = 7'(km); e.b = 7'(kp); end
                5: begin e.sel = LM; e.op = PLS; e.a = 7'(l);  e.b = 7'(k);  end
                default: begin e.sel = LP; e.op = PLS; e.a = 7'(k); e.b = 7'(lp); end
            endcase
        end
        return e;
    endfunction

    function automatic beat_t cur();
        beat_t b;
        b.sel  = out_cmd.sel;
        b.op   = out_cmd.op;
        b.a    = out_pos_a;
        b.b    = out_pos_b;
        b.last = out_last;
        b.err  = out_err;
        return b;
    endfunction

    task automatic push_opt(opt_t o);
        for (int i = 0; i < nbeats(o); i++) sb.push_back(model(o, i));
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic accept_opt(opt_t o, output bit ok);
        ok       = 1'b0;
        in_opt   = o;
        in_valid = 1'b1;
        for (int c = 0; c < 20; c++) begin
            #1;
            if (in_ready) begin
                push_opt(o);
                ok = 1'b1;
            end
            tick();
            if (ok) break;
        end
        in_valid = 1'b0;
    endtask

    task automatic collect(output beat_t b, output int w);
        b         = '0;
        w         = -1;
        out_ready = 1'b1;
        for (int c = 0; c < 20; c++) begin
            #1;
            if (out_valid) begin
                b = cur();
                w = c;
            end
            tick();
            if (w >= 0) break;
        end
    endtask

    task automatic test_reset();
        reset     = 1'b1;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        in_opt    = mk(TWO, 1, 4);
        tick();
        tick();
        vectors++;
        if (in_ready !== 1'b0 || out_valid !== 1'b0 || out_cmd.sel !== KN || out_cmd.op !== DNOP ||
            out_pos_a !== 7'd0 || out_pos_b !== 7'd0 || out_last !== 1'b0 || out_err !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_outputs got rdy=%b vld=%b cmd=%h a=%0d b=%0d last=%b err=%b want 0 0 %h 0 0 0 0",
                     in_ready, out_valid, out_cmd, out_pos_a, out_pos_b, out_last, out_err, {KN, DNOP});
        end
        in_valid = 1'b0;
        reset    = 1'b0;
        tick();
        vectors++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_release got in_ready=%b out_valid=%b want 1 0", in_ready, out_valid);
        end
    endtask

    task automatic test_two();
        beat_t b, e;
        int    w;
        bit    ok;
        accept_opt(mk(TWO, 3, 10), ok);
        vectors++;
        if (!ok) begin
            miscompares++;
            $display("FAIL two_accept got no accept want accept");
            return;
        end
        for (int i = 0; i < 5; i++) begin
            collect(b, w);
            e = sb.pop_front();
            vectors++;
            if (b !== e || w != 0) begin
                miscompares++;
                $display("FAIL two_beat%0d got %h wait=%0d want %h wait=0", i, b, w, e);
            end
            if (i == 4) begin
                vectors++;
                if (b.a !== 7'd4 || b.b !== 7'd11 || b.last !== 1'b1) begin
                    miscompares++;
                    $display("FAIL two_final got (%0d,%0d) last=%b want (4,11) last=1", b.a, b.b, b.last);
                end
            end
        end
        vectors++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL two_idle got out_valid=%b in_ready=%b want 0 1", out_valid, in_ready);
        end
    endtask

    task automatic test_or0_wrap();
        beat_t b, e;
        int    w;
        bit    ok;
        accept_opt(mk(OR0, 0, 29), ok);
        vectors++;
        if (!ok) begin
            miscompares++;
            $display("FAIL or0_accept got no accept want accept");
            return;
        end
        for (int i = 0; i < 7; i++) begin
            collect(b, w);
            e = sb.pop_front();
            vectors++;
            if (b !== e || w != 0) begin
                miscompares++;
                $display("FAIL or0_beat%0d got %h wait=%0d want %h wait=0", i, b, w, e);
            end
            if (i == 1) begin
                vectors++;
                if (b.a !== 7'd29 || b.b !== 7'd0) begin
                    miscompares++;
                    $display("FAIL or0_wrap got (%0d,%0d) want (29,0)", b.a, b.b);
                end
            end
        end
    endtask

    task automatic test_or1_stall();
        beat_t b, e;
        int    w;
        bit    ok;
        accept_opt(mk(OR1, 12, 5), ok);
        vectors++;
        if (!ok) begin
            miscompares++;
            $display("FAIL or1_accept got no accept want accept");
            return;
        end
        for (int i = 0; i < 7; i++) begin
            if (i == 1 || i == 4) begin
                out_ready = 1'b0;
                for (int s = 0; s < 3; s++) begin
                    #1;
                    vectors++;
                    if (out_valid !== 1'b1 || in_ready !== 1'b0 || cur() !== sb[0]) begin
                        miscompares++;
                        $display("FAIL or1_hold%0d_%0d got vld=%b rdy=%b %h want 1 0 %h",
                                 i, s, out_valid, in_ready, cur(), sb[0]);
                    end
                    tick();
                end
            end
            collect(b, w);
            e = sb.pop_front();
            vectors++;
            if (b !== e || w != 0) begin
                miscompares++;
                $display("FAIL or1_beat%0d got %h wait=%0d want %h wait=0", i, b, w, e);
            end
        end
    endtask

    task automatic test_invalid();
        opt_t  ops[2];
        beat_t b, e;
        int    w;
        bit    ok;
        ops[0] = mk(THR, 2, 6);
        ops[1] = mk(TWO, 31, 6);
        for (int j = 0; j < 2; j++) begin
            accept_opt(ops[j], ok);
            vectors++;
            if (!ok) begin
                miscompares++;
                $display("FAIL inv%0d_accept got no accept want accept", j);
                continue;
            end
            collect(b, w);
            e = sb.pop_front();
            vectors++;
            if (b !== e || w != 0 || b.op !== ZERO || b.last !== 1'b1 || b.err !== 1'b1) begin
                miscompares++;
                $display("FAIL inv%0d_beat got %h wait=%0d want %h wait=0", j, b, w, e);
            end
            #1;
            vectors++;
            if (out_valid !== 1'b0) begin
                miscompares++;
                $display("FAIL inv%0d_single got out_valid=%b want 0", j, out_valid);
            end
            tick();
        end
    endtask

    task automatic test_back_to_back();
        opt_t  o1, o2;
        beat_t e;
        int    got, acc;
        o1        = mk(TWO, 7, 20);
        o2        = mk(OR0, 15, 2);
        in_opt    = o1;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        got       = 0;
        acc       = 0;
        for (int c = 0; c < 40 && got < 12; c++) begin
            #1;
            if (out_valid) begin
                e = (sb.size() > 0) ? sb.pop_front() : '0;
                vectors++;
                if (cur() !== e) begin
                    miscompares++;
                    $display("FAIL b2b_beat%0d got %h want %h", got, cur(), e);
                end
                got++;
            end else if (got > 0) begin
                vectors++;
                miscompares++;
                $display("FAIL b2b_gap after beat %0d got out_valid=0 want 1", got);
            end
            if (in_valid && in_ready) begin
                push_opt(acc == 0 ? o1 : o2);
                acc++;
            end
            tick();
            if (acc == 1) in_opt = o2;
            if (acc >= 2) in_valid = 1'b0;
        end
        in_valid = 1'b0;
        vectors++;
        if (got != 12 || acc != 2) begin
            miscompares++;
            $display("FAIL b2b_count got beats=%0d accepts=%0d want 12 2", got, acc);
        end
    endtask

    task automatic test_reset_mid();
        beat_t b, e;
        int    w;
        bit    ok;
        accept_opt(mk(OR0, 4, 9), ok);
        vectors++;
        if (!ok) begin
            miscompares++;
            $display("FAIL rmid_accept got no accept want accept");
            return;
        end
        for (int i = 0; i < 2; i++) begin
            collect(b, w);
            e = sb.pop_front();
            vectors++;
            if (b !== e || w != 0) begin
                miscompares++;
                $display("FAIL rmid_beat%0d got %h wait=%0d want %h wait=0", i, b, w, e);
            end
        end
        reset = 1'b1;
        tick();
        vectors++;
        if (out_valid !== 1'b0 || in_ready !== 1'b0 || out_last !== 1'b0 || out_pos_a !== 7'd0) begin
            miscompares++;
            $display("FAIL rmid_in_reset got vld=%b rdy=%b last=%b a=%0d want 0 0 0 0",
                     out_valid, in_ready, out_last, out_pos_a);
        end
        reset = 1'b0;
        tick();
        vectors++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL rmid_release got in_ready=%b out_valid=%b want 1 0", in_ready, out_valid);
        end
        tick();
        vectors++;
        if (out_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL rmid_discard got out_valid=%b want 0", out_valid);
        end
        sb.delete();
    endtask

    initial begin
        reset     = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        in_opt    = '0;
        test_reset();
        test_two();
        test_or0_wrap();
        test_or1_stall();
        test_invalid();
        test_back_to_back();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
